// File: rtl/experiar_gpio_peripheral.sv
// Wishbone GPIO bank: OUT/OE/IN registers, SET/CLR/TGL strobes, byte-lane writes.
// Define GPIO_BLINK_EN to add the free-running blink divider on blink_o (offset 0x18).

module experiar_gpio_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];
endmodule

module experiar_gpio_peripheral #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oeb,
  output logic             blink_o
);
  localparam logic [7:0] OFF_OUT = 8'h00;
  localparam logic [7:0] OFF_OE  = 8'h04;
  localparam logic [7:0] OFF_IN  = 8'h08;
  localparam logic [7:0] OFF_SET = 8'h0C;
  localparam logic [7:0] OFF_CLR = 8'h10;
  localparam logic [7:0] OFF_TGL = 8'h14;
  localparam logic [7:0] OFF_DIV = 8'h18;

  logic [WIDTH-1:0] out_q, out_nxt, oe_q, in_sync, wmask, wdata;
  logic [31:0]      byte_mask, rdata;
  logic [7:0]       off;
  logic             hit, req, wr;

  assign off       = wbs_adr_i[7:0];
  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req       = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr        = req & wbs_we_i;
  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask     = byte_mask[WIDTH-1:0];
  assign wdata     = wbs_dat_i[WIDTH-1:0] & wmask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    experiar_gpio_sync u_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (gpio_in[i]),
      .q   (in_sync[i])
    );
  end

`ifdef GPIO_BLINK_EN
  logic [23:0] div_q, cnt_q;
  logic        blink_q;
  logic        div_wr;

  assign div_wr = wr & (off == OFF_DIV);

  // A DIV write restarts the period; DIV below the current count clears on the next edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_q   <= 24'd1_000_000;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (div_wr) begin
      div_q <= (div_q & ~byte_mask[23:0]) | (wbs_dat_i[23:0] & byte_mask[23:0]);
      cnt_q <= '0;
    end else if (div_q == '0) begin
      cnt_q <= '0;
    end else if (cnt_q >= div_q) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  assign blink_o = blink_q;
`else
  assign blink_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT: rdata = 32'(out_q);
      OFF_OE:  rdata = 32'(oe_q);
      OFF_IN:  rdata = 32'(in_sync);
`ifdef GPIO_BLINK_EN
      OFF_DIV: rdata = 32'(div_q);
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    out_nxt = out_q;
    if (wr) begin
      case (off)
        OFF_OUT: out_nxt = (out_q & ~wmask) | wdata;
        OFF_SET: out_nxt = out_q | wdata;
        OFF_CLR: out_nxt = out_q & ~wdata;
        OFF_TGL: out_nxt = out_q ^ wdata;
        default: out_nxt = out_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q     <= '0;
      oe_q      <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      out_q     <= out_nxt;
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : 32'd0;
      if (wr && off == OFF_OE) oe_q <= (oe_q & ~wmask) | wdata;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oeb = ~oe_q;

  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i, byte_mask};
endmodule

// File: tb/tb_experiar_gpio_peripheral.sv
// Table-driven bench for experiar_gpio_peripheral with a read-data scoreboard.
// Blink checks compile in when GPIO_BLINK_EN is defined.

module tb_experiar_gpio_peripheral;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] gpio_in, gpio_out, gpio_oeb;
  logic        blink;

  always #5 clk = ~clk;

  experiar_gpio_peripheral #(.WIDTH(16), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb),
    .blink_o   (blink)
  );

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oeb;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [7:0] o, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] rd, input logic [15:0] eo, input logic [15:0] eb);
    vec_t v;
    v.we = w; v.off = o; v.sel = s; v.dat = d; v.exp_rd = rd; v.exp_out = eo; v.exp_oeb = eb;
    vecs.push_back(v);
  endtask

  // One classic cycle; expected read data enters the scoreboard when driven.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_ack, input string name);
    logic        got;
    logic [31:0] e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    sb.push_back(exp_rd);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    e = sb.pop_front();
    chk({name, " ack"}, 32'(got), 32'(exp_ack));
    if (got) chk({name, " rdata"}, dat_o, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  walk[9];
    logic [15:0] pat;
    logic        b0;
    int          n;

    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0; gpio_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gpio_out", 32'(gpio_out), 32'h0);
    chk("reset gpio_oeb", 32'(gpio_oeb), 32'hFFFF);
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset dat_o", dat_o, 32'h0);
    chk("reset blink", 32'(blink), 32'h0);
    @(negedge clk); rst = 1'b0;
    xfer(1'b0, BASE + 32'h04, 4'hF, 32'h0, 32'h0, 1'b1, "reset OE read");

    // Vector table
    add(1'b1, 8'h04, 4'hF, 32'h0000_F000, 32'h0, 16'h0000, 16'h0FFF);
    walk = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    for (int i = 0; i < 9; i++) begin
      pat = {walk[i], 12'h000};
      add(1'b1, 8'h00, 4'hF, 32'(pat), 32'h0, pat, 16'h0FFF);
      add(1'b0, 8'h00, 4'hF, 32'h0, 32'(pat), pat, 16'h0FFF);
    end
    add(1'b1, 8'h00, 4'hF, 32'h0000_00F0, 32'h0, 16'h00F0, 16'h0FFF);
    add(1'b1, 8'h0C, 4'hF, 32'h0000_0F00, 32'h0, 16'h0FF0, 16'h0FFF);
    add(1'b1, 8'h10, 4'hF, 32'h0000_00F0, 32'h0, 16'h0F00, 16'h0FFF);
    add(1'b1, 8'h14, 4'hF, 32'h0000_FFFF, 32'h0, 16'hF0FF, 16'h0FFF);
    add(1'b0, 8'h0C, 4'hF, 32'h0, 32'h0, 16'hF0FF, 16'h0FFF);
    add(1'b0, 8'h04, 4'hF, 32'h0, 32'h0000_F000, 16'hF0FF, 16'h0FFF);
    add(1'b1, 8'h00, 4'b0001, 32'h0000_ABCD, 32'h0, 16'hF0CD, 16'h0FFF);
    add(1'b1, 8'h00, 4'hF, 32'h0000_0000, 32'h0, 16'h0000, 16'h0FFF);
    add(1'b1, 8'h00, 4'b0001, 32'h0000_ABCD, 32'h0, 16'h00CD, 16'h0FFF);
    add(1'b0, 8'h00, 4'hF, 32'h0, 32'h0000_00CD, 16'h00CD, 16'h0FFF);
    add(1'b0, 8'h40, 4'hF, 32'h0, 32'h0, 16'h00CD, 16'h0FFF);
    add(1'b1, 8'h08, 4'hF, 32'h0000_FFFF, 32'h0, 16'h00CD, 16'h0FFF);
    add(1'b1, 8'h00, 4'b0010, 32'h0000_5600, 32'h0, 16'h56CD, 16'h0FFF);
    add(1'b1, 8'h00, 4'hF, 32'hFFFF_1234, 32'h0, 16'h1234, 16'h0FFF);
    add(1'b0, 8'h00, 4'hF, 32'h0, 32'h0000_1234, 16'h1234, 16'h0FFF);
`ifdef GPIO_BLINK_EN
    add(1'b0, 8'h18, 4'hF, 32'h0, 32'd1_000_000, 16'h1234, 16'h0FFF);
`else
    add(1'b0, 8'h18, 4'hF, 32'h0, 32'h0, 16'h1234, 16'h0FFF);
`endif

    foreach (vecs[i]) begin
      xfer(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].sel, vecs[i].dat, vecs[i].exp_rd, 1'b1,
           $sformatf("vec%0d", i));
      chk($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d gpio_oeb", i), 32'(gpio_oeb), 32'(vecs[i].exp_oeb));
    end

    xfer(1'b1, BASE + 32'h100, 4'hF, 32'h0000_FFFF, 32'h0, 1'b0, "foreign write");
    chk("foreign gpio_out", 32'(gpio_out), 32'h1234);

    // Held strobe: acks on alternate cycles, dat_o zero between them
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) n++;
      else     chk("held idle dat_o", dat_o, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held ack count", 32'(n), 32'd3);
    @(posedge clk); #1;
    chk("ack drops", 32'(ack), 32'h0);

    @(negedge clk); gpio_in = 16'h5A5A;
    repeat (2) @(posedge clk);
    xfer(1'b0, BASE + 32'h08, 4'hF, 32'h0, 32'h0000_5A5A, 1'b1, "input read");

`ifdef GPIO_BLINK_EN
    xfer(1'b1, BASE + 32'h18, 4'hF, 32'd4, 32'h0, 1'b1, "div4 write");
    b0 = blink;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("blink k%0d", k), 32'(blink), 32'(b0 ^ (k >= 5) ^ (k >= 10)));
    end
    xfer(1'b1, BASE + 32'h18, 4'hF, 32'd0, 32'h0, 1'b1, "div0 write");
    b0 = blink;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("blink hold k%0d", k), 32'(blink), 32'(b0));
    end
`endif

    // Reset during a read: no ack, no data, registers back to reset
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h08; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid-read ack", 32'(ack), 32'h0);
    chk("rst mid-read dat_o", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("post-rst gpio_out", 32'(gpio_out), 32'h0);
    chk("post-rst gpio_oeb", 32'(gpio_oeb), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
